// File: rtl/an_encoder_16bits.sv
// AN-code encoder: W = A*N by serial shift-and-add, valid/ready on both sides.
// Ports: clk, rst_n, in_valid/in_ready/n_in, out_valid/out_ready/w_out, busy.
// Optional AN_ENC_ERR_INJ_EN adds inj_en, inj_pos1/2, inj_sgn1/2 and an INJ
// state that adds up to two +/-2^pos error terms to the codeword.
module an_encoder_16bits #(
    parameter int unsigned A      = 4547,
    parameter int unsigned N_BITS = 17,
    parameter int unsigned W_BITS = 30,
    parameter int unsigned A_BITS = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_BITS-1:0] n_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W_BITS-1:0] w_out,
    output logic              busy
`ifdef AN_ENC_ERR_INJ_EN
    ,
    input  logic              inj_en,
    input  logic [4:0]        inj_pos1,
    input  logic              inj_sgn1,
    input  logic [4:0]        inj_pos2,
    input  logic              inj_sgn2
`endif
);

    localparam logic [A_BITS-1:0] A_C = A_BITS'(A);
    localparam logic [W_BITS-1:0] A_W = W_BITS'(A_C);
    localparam logic [4:0]        LAST = 5'(N_BITS - 1);

`ifdef AN_ENC_ERR_INJ_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        INJ  = 2'd2,
        OUT  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        OUT  = 2'd2
    } state_t;
`endif

    state_t            state;
    logic [N_BITS-1:0] n_q;
    logic [W_BITS-1:0] acc;
    logic [4:0]        cnt;

    logic [W_BITS-1:0] partial;
    logic [W_BITS-1:0] acc_next;
    logic              last_bit;

    // One partial product per cycle; bit cnt of N selects A << cnt.
    always_comb begin
        partial  = '0;
        if (n_q[cnt])
            partial = A_W << cnt;
        acc_next = acc + partial;
        last_bit = (cnt == LAST);
    end

`ifdef AN_ENC_ERR_INJ_EN
    logic              en_q;
    logic [4:0]        pos1_q;
    logic              sgn1_q;
    logic [4:0]        pos2_q;
    logic              sgn2_q;
    logic [W_BITS-1:0] err1;
    logic [W_BITS-1:0] err2;
    logic [W_BITS-1:0] w_inj;

    // +/-2^pos modulo 2^W_BITS; positions past the word add nothing.
    function automatic logic [W_BITS-1:0] err_term(
        input logic [4:0] pos,
        input logic       sgn
    );
        logic [W_BITS-1:0] m;
        m = '0;
        if (32'(pos) < W_BITS)
            m = W_BITS'(1) << pos;
        if (sgn)
            m = ~m + W_BITS'(1);
        return m;
    endfunction

    always_comb begin
        err1  = err_term(pos1_q, sgn1_q);
        err2  = err_term(pos2_q, sgn2_q);
        w_inj = acc;
        if (en_q)
            w_inj = acc + err1 + err2;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            n_q       <= '0;
            acc       <= '0;
            cnt       <= '0;
            w_out     <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
`ifdef AN_ENC_ERR_INJ_EN
            en_q      <= 1'b0;
            pos1_q    <= '0;
            sgn1_q    <= 1'b0;
            pos2_q    <= '0;
            sgn2_q    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        n_q      <= n_in;
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= MUL;
`ifdef AN_ENC_ERR_INJ_EN
                        en_q     <= inj_en;
                        pos1_q   <= inj_pos1;
                        sgn1_q   <= inj_sgn1;
                        pos2_q   <= inj_pos2;
                        sgn2_q   <= inj_sgn2;
`endif
                    end
                end
                MUL: begin
                    acc <= acc_next;
                    cnt <= cnt + 5'd1;
                    if (last_bit) begin
`ifdef AN_ENC_ERR_INJ_EN
                        state <= INJ;
`else
                        w_out     <= acc_next;
                        out_valid <= 1'b1;
                        state     <= OUT;
`endif
                    end
                end
`ifdef AN_ENC_ERR_INJ_EN
                INJ: begin
                    w_out     <= w_inj;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
`endif
                OUT: begin
                    // Hold the codeword until the consumer takes it.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/an_encoder_16bits.md
AN_ENCODER_16BITS -- requirements
Module: an_encoder_16bits

Interface
REQ-001 Parameter A, default 4547: AN-code multiplier constant.
REQ-002 Parameter N_BITS, default 17: data word width.
REQ-003 Parameter W_BITS, default 30: codeword width.
REQ-004 Parameter A_BITS, default 13: width of A.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  n_in valid.
REQ-008 in_ready  output  1  encoder can accept a word.
REQ-009 n_in  input  N_BITS  unsigned data word N.
REQ-010 out_valid  output  1  w_out holds a finished codeword.
REQ-011 out_ready  input  1  downstream accepts w_out.
REQ-012 w_out  output  W_BITS  codeword W = A*N (plus injected error when enabled).
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, MUL, INJ (present only with ERR_INJ_EN), and OUT.
REQ-015 in_ready SHALL be 1 only in IDLE; a transfer occurs on a rising edge with in_valid&in_ready=1.
REQ-016 On a transfer, the block SHALL latch n_in, clear the accumulator and the 5-bit bit counter cnt, and enter MUL.
REQ-017 Each MUL cycle SHALL add (A << cnt) to the accumulator when N[cnt]=1 and SHALL then increment cnt; the add uses W_BITS-wide unsigned arithmetic.
REQ-018 The MUL cycle with cnt=N_BITS-1 SHALL exit to INJ (macro defined) or to OUT (macro undefined), so MUL lasts exactly N_BITS cycles.
REQ-019 On entering OUT, out_valid SHALL rise and w_out SHALL load the final codeword; latency from the transfer edge to out_valid high is 17 cycles without the macro and 18 with it.
REQ-020 In OUT, w_out and out_valid SHALL hold stable while out_ready=0.
REQ-021 On a rising edge with out_valid&out_ready=1, the FSM SHALL return to IDLE with out_valid=0; in_ready becomes 1 the next cycle, with no same-cycle accept.
REQ-022 in_valid and n_in SHALL be ignored outside IDLE.
REQ-023 A*(2^N_BITS-1)=595979837 fits in W_BITS, so the block SHALL never overflow for legal parameters.
REQ-024 The result SHALL satisfy w_out mod A = 0 whenever no error is injected.

Reset
REQ-025 While rst_n=0: state=IDLE, out_valid=0, w_out=0, accumulator=0, cnt=0, latched N=0, busy=0, and in_ready=1 after release.
REQ-026 Reset asserted mid-operation (MUL/INJ/OUT) SHALL abort the word with no output produced; the first transfer after release behaves as from power-up.

Configuration
REQ-027 Macro AN_ENC_ERR_INJ_EN, when defined, SHALL add these inputs: inj_en(1), inj_pos1(5), inj_sgn1(1), inj_pos2(5), inj_sgn2(1), all sampled with n_in on the transfer.
REQ-028 With the macro defined, the INJ state (one cycle) SHALL, if inj_en=1, add +2^pos (sgn=0) or -2^pos (sgn=1) for each position, modulo 2^W_BITS; a position value >= W_BITS means no error for that term.
REQ-029 This matches the decoder error model: error location l = +/-(pos+1).
REQ-030 Without the macro, the ports and the INJ state SHALL not exist, and MUL SHALL go directly to OUT.

Verification
REQ-031 Reset, then n_in=1 with out_ready=1 -> out_valid at +17 cycles, w_out=4547, then in_ready=1.
REQ-032 n_in=0 -> w_out=0; n_in=131071 -> w_out=595979837.
REQ-033 n_in=100 with out_ready held 0 for 10 cycles -> w_out=454700 stable, out_valid=1 throughout; completes when out_ready rises, and in_valid pulses during busy are ignored.
REQ-034 AN_ENC_ERR_INJ_EN: n_in=5, inj_en=1, pos1=3 sgn1=0, pos2=31 -> w_out=22743 at +18 cycles; with pos1=0 sgn1=1, pos2=4 sgn2=0 -> w_out=22750.
REQ-035 rst_n pulsed low during MUL cycle 8 of n_in=77 -> out_valid stays 0, in_ready=1 after release; next n_in=2 -> w_out=9094.
REQ-036 Random n_in stream (>=1000 words) with random out_ready -> every w_out equals 4547*n_in and every w_out mod 4547 = 0.
